// File: rtl/decode_stage_pkg.sv
// Shared decode constants: ALU op codes, RV32I opcode/funct values, immediate formats
// and the decode-to-execute pipeline register layout.
package decode_stage_pkg;

  localparam int REG_DATA_WIDTH = 32;
  localparam int ALU_OP_WIDTH   = 4;
  localparam int XLEN           = REG_DATA_WIDTH;
  localparam int OPW            = ALU_OP_WIDTH;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9,
    ALU_SEQ  = 4'd10,
    ALU_SNE  = 4'd11,
    ALU_SGE  = 4'd12,
    ALU_SGEU = 4'd13
  } alu_op_e;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_SH   = 3'd6
  } imm_fmt_e;

  typedef enum logic [1:0] {A_ZERO, A_PC, A_RS1} a_sel_e;
  typedef enum logic [1:0] {B_IMM, B_FOUR, B_RS2} b_sel_e;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    alu_op_e         alu_op;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs2;
    logic [4:0]      rd;
    logic            we;
    logic            branch;
    logic            jump;
    logic            jalr;
    logic            load;
    logic            store;
    logic [2:0]      funct3;
    logic            illegal;
  } ex_reg_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate extraction for RV32I formats, sign-extended (shift amounts zero-extended).
// Latency: purely combinational.
// Backpressure: none, stateless.
module decode_stage_imm_gen
  import decode_stage_pkg::*;
(
  input  logic [31:7]     instr,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] raw;

  always_comb begin
    raw = '0;
    case (fmt)
      IMM_I:   raw = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   raw = {instr[31:12], 12'b0};
      IMM_J:   raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_SH:  raw = {27'b0, instr[24:20]};
      default: raw = '0;
    endcase
  end

  assign imm = XLEN'($signed(raw));

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: instruction -> ALU op/operands/control, with RAW scoreboard stall.
// Latency: 1 cycle from fetch accept to ex_valid; 1 instr/cycle when ex_ready high and no hazard.
// Backpressure: ex_* held while ex_valid && !ex_ready; if_ready drops on hazard, flush or full register.
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [OPW-1:0]  ex_alu_op,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs2,
  output logic [4:0]      ex_rd,
  output logic            ex_we,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic            ex_jalr,
  output logic            ex_load,
  output logic            ex_store,
  output logic [2:0]      ex_funct3,
  output logic            ex_illegal,
  input  logic            flush,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rd_field;

  imm_fmt_e        fmt;
  a_sel_e          a_sel;
  b_sel_e          b_sel;
  alu_op_e         op;
  logic            use_rs1, use_rs2, has_rd;
  logic            is_branch, is_jump, is_jalr, is_load, is_store, is_illegal;
  logic [XLEN-1:0] imm;

  ex_reg_t         dec;
  ex_reg_t         ex_q;
  logic [31:0]     sb, sb_nxt;
  logic            busy1, busy2, hazard, capture, retire;

  assign opcode   = if_instr[6:0];
  assign rd_field = if_instr[11:7];
  assign funct3   = if_instr[14:12];
  assign funct7   = if_instr[31:25];
  assign rs1_addr = if_instr[19:15];
  assign rs2_addr = if_instr[24:20];

  always_comb begin
    fmt        = IMM_NONE;
    a_sel      = A_ZERO;
    b_sel      = B_IMM;
    op         = ALU_ADD;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    has_rd     = 1'b0;
    is_branch  = 1'b0;
    is_jump    = 1'b0;
    is_jalr    = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OPC_LUI: begin
        fmt    = IMM_U;
        has_rd = 1'b1;
      end
      OPC_AUIPC: begin
        fmt    = IMM_U;
        a_sel  = A_PC;
        has_rd = 1'b1;
      end
      OPC_JAL: begin
        fmt     = IMM_J;
        a_sel   = A_PC;
        b_sel   = B_FOUR;
        has_rd  = 1'b1;
        is_jump = 1'b1;
      end
      OPC_JALR: begin
        fmt     = IMM_I;
        a_sel   = A_PC;
        b_sel   = B_FOUR;
        use_rs1 = 1'b1;
        has_rd  = 1'b1;
        is_jalr = 1'b1;
      end
      OPC_BRANCH: begin
        fmt       = IMM_B;
        a_sel     = A_RS1;
        b_sel     = B_RS2;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        is_branch = 1'b1;
        case (funct3)
          F3_BEQ:  op = ALU_SEQ;
          F3_BNE:  op = ALU_SNE;
          F3_BLT:  op = ALU_SLT;
          F3_BGE:  op = ALU_SGE;
          F3_BLTU: op = ALU_SLTU;
          F3_BGEU: op = ALU_SGEU;
          default: is_illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        fmt     = IMM_I;
        a_sel   = A_RS1;
        use_rs1 = 1'b1;
        has_rd  = 1'b1;
        is_load = 1'b1;
      end
      OPC_STORE: begin
        fmt      = IMM_S;
        a_sel    = A_RS1;
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        is_store = 1'b1;
      end
      OPC_OPIMM: begin
        fmt     = IMM_I;
        a_sel   = A_RS1;
        use_rs1 = 1'b1;
        has_rd  = 1'b1;
        case (funct3)
          F3_ADD:  op = ALU_ADD;
          F3_SLT:  op = ALU_SLT;
          F3_SLTU: op = ALU_SLTU;
          F3_XOR:  op = ALU_XOR;
          F3_OR:   op = ALU_OR;
          F3_AND:  op = ALU_AND;
          F3_SLL: begin
            fmt        = IMM_SH;
            op         = ALU_SLL;
            is_illegal = (funct7 != F7_BASE);
          end
          default: begin
            fmt = IMM_SH;
            if (funct7 == F7_BASE)     op = ALU_SRL;
            else if (funct7 == F7_ALT) op = ALU_SRA;
            else                       is_illegal = 1'b1;
          end
        endcase
      end
      OPC_OP: begin
        a_sel   = A_RS1;
        b_sel   = B_RS2;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        has_rd  = 1'b1;
        if (funct7 == F7_BASE) begin
          case (funct3)
            F3_ADD:  op = ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = ALU_SRL;
            F3_OR:   op = ALU_OR;
            default: op = ALU_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == F3_ADD) begin
          op = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == F3_SR) begin
          op = ALU_SRA;
        end else begin
          is_illegal = 1'b1;
        end
      end
      default: is_illegal = 1'b1;
    endcase

    // Illegal encodings issue as an inert ADD 0,0 with no sources and no writeback.
    if (is_illegal) begin
      fmt       = IMM_NONE;
      a_sel     = A_ZERO;
      b_sel     = B_IMM;
      op        = ALU_ADD;
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
      has_rd    = 1'b0;
      is_branch = 1'b0;
      is_jump   = 1'b0;
      is_jalr   = 1'b0;
      is_load   = 1'b0;
      is_store  = 1'b0;
    end
  end

  decode_stage_imm_gen u_imm_gen (
    .instr (if_instr[31:7]),
    .fmt   (fmt),
    .imm   (imm)
  );

  always_comb begin
    dec = '0;
    case (a_sel)
      A_PC:    dec.a = if_pc;
      A_RS1:   dec.a = rs1_data;
      default: dec.a = '0;
    endcase
    case (b_sel)
      B_FOUR:  dec.b = XLEN'(4);
      B_RS2:   dec.b = rs2_data;
      default: dec.b = imm;
    endcase
    dec.alu_op  = op;
    dec.imm     = imm;
    dec.pc      = if_pc;
    dec.rs2     = use_rs2 ? rs2_data : '0;
    dec.rd      = has_rd ? rd_field : 5'd0;
    dec.we      = has_rd && (rd_field != 5'd0);
    dec.branch  = is_branch;
    dec.jump    = is_jump;
    dec.jalr    = is_jalr;
    dec.load    = is_load;
    dec.store   = is_store;
    dec.funct3  = funct3;
    dec.illegal = is_illegal;
  end

  // A register is busy while its producer sits in the output register or until writeback.
  assign busy1 = (rs1_addr != 5'd0) &&
                 (sb[rs1_addr] || (ex_valid && ex_q.we && ex_q.rd == rs1_addr));
  assign busy2 = (rs2_addr != 5'd0) &&
                 (sb[rs2_addr] || (ex_valid && ex_q.we && ex_q.rd == rs2_addr));
  assign hazard   = (use_rs1 && busy1) || (use_rs2 && busy2);
  assign if_ready = !flush && !hazard && (!ex_valid || ex_ready);
  assign capture  = if_valid && if_ready;
  assign retire   = ex_valid && ex_ready && ex_q.we && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_q     <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (capture) begin
      ex_valid <= 1'b1;
      ex_q     <= dec;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

  // Set after clear so a producer issuing the same rd as a retiring write stays pending.
  always_comb begin
    sb_nxt = sb;
    if (wb_valid) sb_nxt[wb_rd] = 1'b0;
    if (retire)   sb_nxt[ex_q.rd] = 1'b1;
    sb_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb <= '0;
    else        sb <= sb_nxt;
  end

  assign ex_a       = ex_q.a;
  assign ex_b       = ex_q.b;
  assign ex_alu_op  = ex_q.alu_op;
  assign ex_imm     = ex_q.imm;
  assign ex_pc      = ex_q.pc;
  assign ex_rs2     = ex_q.rs2;
  assign ex_rd      = ex_q.rd;
  assign ex_we      = ex_q.we;
  assign ex_branch  = ex_q.branch;
  assign ex_jump    = ex_q.jump;
  assign ex_jalr    = ex_q.jalr;
  assign ex_load    = ex_q.load;
  assign ex_store   = ex_q.store;
  assign ex_funct3  = ex_q.funct3;
  assign ex_illegal = ex_q.illegal;

endmodule
